// File: rtl/gf_serial_seq.sv
// Sequencing controller for the serial-I/O GF carry-less arithmetic wrapper:
// load operands serially, execute, capture, unload results serially, pulse done.
module gf_serial_seq #(
   parameter int DATA_WIDTH  = 32,
   parameter int EXEC_CYCLES = 2
) (
   input  logic                            clk,
   input  logic                            resetn,
   input  logic                            start,
   input  logic                            abort,
   input  logic [1:0]                      op_sel,
   input  logic                            carry_opt_in,
   output logic                            busy,
   output logic                            done,
   output logic                            shift_in_en,
   output logic                            enable,
   output logic                            sum_funct,
   output logic                            exp_funct,
   output logic                            red_funct,
   output logic                            carry_option,
   output logic                            out_load,
   output logic                            out_shift_en,
   output logic [$clog2(2*DATA_WIDTH):0]   bit_cnt
);

   localparam int CW = $clog2(2*DATA_WIDTH) + 1;
   localparam logic [CW-1:0] LAST_BIT  = CW'(2*DATA_WIDTH - 1);
   localparam logic [3:0]    EXEC_LAST = 4'(EXEC_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_EXEC, S_CAPTURE, S_UNLOAD, S_DONE
   } state_t;

   state_t     state;
   logic [3:0] exec_cnt;

   // Every strobe is decided one edge ahead, so each output is a plain flop.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state        <= S_IDLE;
         busy         <= 1'b0;
         done         <= 1'b0;
         shift_in_en  <= 1'b0;
         enable       <= 1'b0;
         out_load     <= 1'b0;
         out_shift_en <= 1'b0;
         sum_funct    <= 1'b0;
         exp_funct    <= 1'b0;
         red_funct    <= 1'b0;
         carry_option <= 1'b0;
         bit_cnt      <= '0;
         exec_cnt     <= '0;
      end else begin
         shift_in_en  <= 1'b0;
         enable       <= 1'b0;
         out_load     <= 1'b0;
         out_shift_en <= 1'b0;
         done         <= 1'b0;
         if (abort && state != S_IDLE) begin
            // Selects are deliberately kept across an abort.
            state    <= S_IDLE;
            busy     <= 1'b0;
            bit_cnt  <= '0;
            exec_cnt <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start && !abort) begin
                     state        <= S_LOAD;
                     busy         <= 1'b1;
                     shift_in_en  <= 1'b1;
                     bit_cnt      <= '0;
                     sum_funct    <= (op_sel == 2'b01);
                     exp_funct    <= (op_sel == 2'b10);
                     red_funct    <= (op_sel == 2'b11);
                     carry_option <= carry_opt_in;
                  end
               end
               S_LOAD: begin
                  if (bit_cnt == LAST_BIT) begin
                     state    <= S_EXEC;
                     enable   <= 1'b1;
                     bit_cnt  <= '0;
                     exec_cnt <= '0;
                  end else begin
                     shift_in_en <= 1'b1;
                     bit_cnt     <= bit_cnt + CW'(1);
                  end
               end
               S_EXEC: begin
                  if (exec_cnt == EXEC_LAST) begin
                     state    <= S_CAPTURE;
                     out_load <= 1'b1;
                  end else begin
                     enable   <= 1'b1;
                     exec_cnt <= exec_cnt + 4'd1;
                  end
               end
               S_CAPTURE: begin
                  state        <= S_UNLOAD;
                  out_shift_en <= 1'b1;
                  bit_cnt      <= '0;
               end
               S_UNLOAD: begin
                  if (bit_cnt == LAST_BIT) begin
                     state   <= S_DONE;
                     done    <= 1'b1;
                     bit_cnt <= '0;
                  end else begin
                     out_shift_en <= 1'b1;
                     bit_cnt      <= bit_cnt + CW'(1);
                  end
               end
               S_DONE: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_gf_serial_seq.sv
// Bench for gf_serial_seq: two instances (4-bit/2-exec and 32-bit/1-exec) share
// inputs and are compared each cycle against a phase-timeline reference model.
module tb_gf_serial_seq;

   logic       clk;
   logic       resetn;
   logic       start;
   logic       abort;
   logic [1:0] op_sel;
   logic       carry_opt_in;

   logic       busy4, done4, si4, en4, sf4, ef4, rf4, co4, ol4, os4;
   logic [3:0] bc4;
   logic       busy32, done32, si32, en32, sf32, ef32, rf32, co32, ol32, os32;
   logic [6:0] bc32;

   int checks   = 0;
   int failures = 0;

   // Reference model state: index 0 = 4-bit instance, 1 = 32-bit instance.
   int  m_w [2] = '{4, 32};
   int  m_e [2] = '{2, 1};
   bit  m_act [2];
   int  m_t [2];
   bit  m_sum [2], m_exp [2], m_red [2], m_car [2];
   int  peak32;

   gf_serial_seq #(.DATA_WIDTH(4), .EXEC_CYCLES(2)) dut4 (
      .clk(clk), .resetn(resetn), .start(start), .abort(abort),
      .op_sel(op_sel), .carry_opt_in(carry_opt_in),
      .busy(busy4), .done(done4), .shift_in_en(si4), .enable(en4),
      .sum_funct(sf4), .exp_funct(ef4), .red_funct(rf4), .carry_option(co4),
      .out_load(ol4), .out_shift_en(os4), .bit_cnt(bc4)
   );

   gf_serial_seq #(.DATA_WIDTH(32), .EXEC_CYCLES(1)) dut32 (
      .clk(clk), .resetn(resetn), .start(start), .abort(abort),
      .op_sel(op_sel), .carry_opt_in(carry_opt_in),
      .busy(busy32), .done(done32), .shift_in_en(si32), .enable(en32),
      .sum_funct(sf32), .exp_funct(ef32), .red_funct(rf32), .carry_option(co32),
      .out_load(ol32), .out_shift_en(os32), .bit_cnt(bc32)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Expected outputs derived from the operation timeline: cycle t=1 is the
   // first load cycle after the accepting edge.
   task automatic check_dut(input string nm, input int i,
                            input logic b, input logic dn, input logic si, input logic en,
                            input logic ol, input logic os, input logic [7:0] bc,
                            input logic sf, input logic ef, input logic rf, input logic co);
      int  load_end, exec_end, cap_t, un_end, t;
      bit  a;
      logic [7:0] exp_bc;
      a        = m_act[i];
      t        = m_t[i];
      load_end = 2 * m_w[i];
      exec_end = load_end + m_e[i];
      cap_t    = exec_end + 1;
      un_end   = cap_t + 2 * m_w[i];
      exp_bc   = 8'd0;
      if (a && t <= load_end) exp_bc = 8'(t - 1);
      else if (a && t > cap_t && t <= un_end) exp_bc = 8'(t - cap_t - 1);
      chk({nm, ".busy"},         8'(b),  8'(a));
      chk({nm, ".shift_in_en"},  8'(si), 8'(a && t <= load_end));
      chk({nm, ".enable"},       8'(en), 8'(a && t > load_end && t <= exec_end));
      chk({nm, ".out_load"},     8'(ol), 8'(a && t == cap_t));
      chk({nm, ".out_shift_en"}, 8'(os), 8'(a && t > cap_t && t <= un_end));
      chk({nm, ".done"},         8'(dn), 8'(a && t == un_end + 1));
      chk({nm, ".bit_cnt"},      bc,     exp_bc);
      chk({nm, ".sum_funct"},    8'(sf), 8'(m_sum[i]));
      chk({nm, ".exp_funct"},    8'(ef), 8'(m_exp[i]));
      chk({nm, ".red_funct"},    8'(rf), 8'(m_red[i]));
      chk({nm, ".carry_option"}, 8'(co), 8'(m_car[i]));
   endtask

   task automatic check_all();
      check_dut("d4",  0, busy4,  done4,  si4,  en4,  ol4,  os4,  8'(bc4),  sf4,  ef4,  rf4,  co4);
      check_dut("d32", 1, busy32, done32, si32, en32, ol32, os32, 8'(bc32), sf32, ef32, rf32, co32);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_act[i] = 0; m_t[i] = 0;
         m_sum[i] = 0; m_exp[i] = 0; m_red[i] = 0; m_car[i] = 0;
      end
   endtask

   task automatic model_edge();
      bit was;
      for (int i = 0; i < 2; i++) begin
         was = m_act[i];
         if (m_act[i] && abort) m_act[i] = 0;
         else if (m_act[i]) begin
            m_t[i]++;
            if (m_t[i] > 8 * m_w[i] / 2 + m_e[i] + 2) m_act[i] = 0;
         end
         if (!was && start && !abort) begin
            m_act[i] = 1;
            m_t[i]   = 1;
            m_sum[i] = (op_sel == 2'b01);
            m_exp[i] = (op_sel == 2'b10);
            m_red[i] = (op_sel == 2'b11);
            m_car[i] = carry_opt_in;
         end
      end
   endtask

   task automatic step(input bit st, input bit ab, input logic [1:0] op, input bit co);
      @(negedge clk);
      start = st; abort = ab; op_sel = op; carry_opt_in = co;
      @(posedge clk);
      model_edge();
      #1;
      if (int'(bc32) > peak32) peak32 = int'(bc32);
      check_all();
   endtask

   // Asserts reset between edges and checks the outputs clear without a clock.
   task automatic async_reset();
      #3;
      start = 0; abort = 0;
      resetn = 1'b0;
      model_reset();
      #1;
      check_all();
      @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic idle_steps(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
   endtask

   initial begin
      resetn = 1'b0; start = 0; abort = 0; op_sel = 2'b00; carry_opt_in = 0;
      peak32 = 0;
      model_reset();
      #3;
      check_all();
      @(negedge clk);
      resetn = 1'b1;

      // Basic mult timeline, selects all zero.
      step(1, 0, 2'b00, 0);
      idle_steps(21);
      async_reset();

      // Reduction with carry; inputs wander during the run.
      step(1, 0, 2'b11, 1);
      idle_steps(21);
      async_reset();

      // Re-starts while busy are ignored; start right after done is taken.
      step(1, 0, 2'b01, 0);
      for (int k = 1; k <= 40; k++)
         step(k == 5 || k == 12 || k == 20 || k == 21, 0, 2'b10, 1);
      async_reset();

      // Abort during EXEC, then abort+start together in IDLE.
      step(1, 0, 2'b10, 1);
      for (int k = 1; k <= 10; k++) step(0, k == 10, 2'b00, 0);
      step(0, 0, 2'b00, 0);
      step(1, 1, 2'b01, 0);
      step(0, 0, 2'b00, 0);
      async_reset();

      // Reset mid-UNLOAD, then the basic timeline again.
      step(1, 0, 2'b01, 1);
      for (int k = 1; k <= 14; k++) step(0, 0, 2'b01, 1);
      async_reset();
      step(1, 0, 2'b00, 0);
      idle_steps(21);
      async_reset();

      // Randomized traffic with occasional restarts and aborts.
      for (int r = 0; r < 8; r++) begin
         for (int k = 0; k < 40; k++)
            step($urandom_range(0, 5) == 0, $urandom_range(0, 30) == 0,
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end
      async_reset();

      // Full 32-bit run: done lands at cycle 131, counter peaks at 63.
      peak32 = 0;
      step(1, 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      idle_steps(133);
      chk("d32.bit_cnt_peak", 8'(peak32), 8'd63);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gf_serial_seq.md
Name: gf_serial_seq

Overview:
- Sequencing controller for the serial-I/O GF carry-less arithmetic wrapper.
- On a host start, it:
  - loads all operand shift chains serially,
  - holds the datapath enable for a fixed number of execute cycles,
  - captures the result registers,
  - shifts the results out serially,
  - signals done.
- Sits between a host/test harness and the wrapper. It drives the wrapper's function selects and all shift/enable strobes.

Parameters:
- DATA_WIDTH, 32, operand width. The longest input or output chain is 2*DATA_WIDTH bits.
- EXEC_CYCLES, 2, number of cycles enable is held high. Legal range 1..15.

Ports:
- clk  input  1  clock
- resetn  input  1  asynchronous active-low reset
- start  input  1  request one operation; sampled only in IDLE
- abort  input  1  synchronous abort; returns the block to IDLE
- op_sel  input  2  operation: 00 mult, 01 sum, 10 exp, 11 reduction
- carry_opt_in  input  1  carry option for the operation
- busy  output  1  high in every state except IDLE
- done  output  1  single-cycle pulse when unload completes
- shift_in_en  output  1  shift strobe for all input chains
- enable  output  1  datapath enable
- sum_funct  output  1  function select, latched
- exp_funct  output  1  function select, latched
- red_funct  output  1  function select, latched
- carry_option  output  1  latched carry option
- out_load  output  1  parallel-capture strobe for the output chains
- out_shift_en  output  1  shift strobe for the output chains
- bit_cnt  output  $clog2(2*DATA_WIDTH)+1  current shift index, for debug

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=IDLE.
  - All outputs 0, including the latched selects and bit_cnt.
- States: IDLE, LOAD, EXEC, CAPTURE, UNLOAD, DONE. One-hot or binary encoding is acceptable.
- IDLE:
  - If start=1 at a clock edge, move to LOAD and latch the selects on that edge:
    - op_sel 01 sets sum_funct.
    - op_sel 10 sets exp_funct.
    - op_sel 11 sets red_funct.
    - op_sel 00 clears all three selects.
  - Latch carry_option from carry_opt_in on the same edge.
  - Clear bit_cnt.
- LOAD:
  - shift_in_en=1.
  - bit_cnt increments each cycle.
  - After exactly 2*DATA_WIDTH cycles (bit_cnt reaches 2*DATA_WIDTH-1), go to EXEC and clear the counter.
  - Shorter chains receive extra shifts. The host must present the MSB-first data aligned so that the last bits land correctly. This is a host obligation, not a block obligation.
- EXEC:
  - enable=1 for exactly EXEC_CYCLES cycles, then go to CAPTURE.
- CAPTURE:
  - out_load=1 for one cycle, then go to UNLOAD with the counter cleared.
- UNLOAD:
  - out_shift_en=1 for exactly 2*DATA_WIDTH cycles, then go to DONE.
- DONE:
  - done=1 for one cycle, then go to IDLE.
  - The selects keep their values until the next start.
- Latency:
  - start sampled at edge 0.
  - First shift_in_en cycle is cycle 1.
  - done is asserted in cycle 1 + 2*DATA_WIDTH + EXEC_CYCLES + 1 + 2*DATA_WIDTH.
- Strobes:
  - Strobes are registered, state-decoded outputs with no combinational path from inputs.
  - shift_in_en, enable, out_load and out_shift_en are mutually exclusive.
- start while busy: ignored and not queued.
- start in the DONE cycle: ignored. A new start is accepted only in IDLE, at the earliest on the cycle after done.
- abort:
  - From any non-IDLE state, abort=1 at an edge forces IDLE on that edge.
  - All strobes and busy deassert next cycle. done is not pulsed.
  - Latched selects are retained.
  - abort and start together in IDLE: abort wins and the block stays in IDLE.
- Reset mid-operation: immediate return to IDLE with all outputs 0. No done pulse.
- Counter: sized so that the count 2*DATA_WIDTH never wraps. No overflow is possible.

Test Plan:
- DATA_WIDTH=4, EXEC_CYCLES=2, op_sel=00, start pulse at edge 0:
  - shift_in_en high cycles 1-8.
  - enable high cycles 9-10.
  - out_load high cycle 11.
  - out_shift_en high cycles 12-19.
  - done high cycle 20.
  - busy high cycles 1-20.
  - All selects 0.
- op_sel=11, carry_opt_in=1 at start; inputs change during LOAD:
  - red_funct=1, sum_funct=exp_funct=0, carry_option=1, stable through DONE.
- start re-pulsed at cycles 5, 12 and 20 during the first run:
  - No effect; exactly one done at cycle 20.
  - A start at cycle 21 begins a new LOAD at cycle 22.
- abort=1 at cycle 10 (EXEC):
  - From cycle 11: busy=0, enable=0, state IDLE.
  - No out_load and no done.
  - abort+start together in IDLE: stays IDLE.
- resetn pulled low asynchronously mid-UNLOAD (cycle 15):
  - All outputs 0 immediately, without waiting for a clock edge.
  - After release, start gives the same timeline as the first scenario.
- DATA_WIDTH=32, EXEC_CYCLES=1:
  - done at cycle 1+64+1+1+64 = 131.
  - bit_cnt peaks at 63 in both LOAD and UNLOAD.
